mul_pipe: RTL and testbench

//   Parametrised, fully pipelined RV32M/RV64M multiply unit (MUL/MULH/MULHSU/MULHU) for the EX stage.

---
 rtl/mul_pipe.sv | 169 ++++++++++++++++
 tb/tb_mul_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe.sv
// ----------------------------------------------------------------------------
// mul_pipe
//   Fully pipelined RV32M/RV64M multiply unit for the EX stage. It executes
//   MUL, MULH, MULHSU and MULHU with one op accepted per cycle, and returns
//   results in issue order exactly LATENCY cycles after acceptance.
//
//   Pipeline organisation:
//     - level 0 captures the accepted operands, funct3 and rd tag;
//     - levels 1..LATENCY carry the full 2*XLEN product;
//     - level LATENCY drives the out_* ports.
//   An op accepted at edge k is therefore visible at the output from edge
//   k+LATENCY. All levels advance together and hold together on a stall.
//
// Parameters
//   XLEN     operand/result width (32 or 64)
//   LATENCY  accept-to-result latency in cycles (1..8)
//   TAG_W    width of the rd tag carried with each op
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   flush       kills every op in flight and any op offered this cycle
//   in_valid    op offered
//   in_ready    unit can accept (combinational, = !stall)
//   in_funct3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx -> result 0
//   in_a/in_b   rs1/rs2 operands
//   in_tag      rd tag, returned unchanged with the result
//   out_valid   result present
//   out_ready   consumer takes the result when out_valid && out_ready
//   out_result  selected product bits
//   out_tag     tag of the op in out_result
//   busy        any pipeline level holds a valid op
// ----------------------------------------------------------------------------
module mul_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PW = 2 * XLEN;

    // Full-width product with the per-opcode operand extension. Multiplying
    // the two 2*XLEN extended operands and keeping the low 2*XLEN bits is
    // exact for any signed/unsigned operand mix (two's complement).
    function automatic logic [PW-1:0] mul_full(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      f3
    );
        logic          a_sgn;
        logic          b_sgn;
        logic [PW-1:0] a_x;
        logic [PW-1:0] b_x;
        // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH
        a_sgn = (f3[1:0] != 2'b11) & a[XLEN-1];
        b_sgn = (f3[1]   == 1'b0)  & b[XLEN-1];
        a_x   = {{XLEN{a_sgn}}, a};
        b_x   = {{XLEN{b_sgn}}, b};
        return a_x * b_x;
    endfunction

    // Picks the architectural result bits out of the full product.
    function automatic logic [XLEN-1:0] sel_result(
        input logic [PW-1:0] p,
        input logic [2:0]    f3
    );
        logic [XLEN-1:0] r;
        if (f3[2]) begin
            r = {XLEN{1'b0}};
        end else if (f3[1:0] == 2'b00) begin
            r = p[XLEN-1:0];
        end else begin
            r = p[PW-1:XLEN];
        end
        return r;
    endfunction

    logic             v_r   [0:LATENCY];
    logic [TAG_W-1:0] tag_r [0:LATENCY];
    logic [2:0]       f3_r  [0:LATENCY];
    logic [PW-1:0]    p_r   [1:LATENCY];
    logic [XLEN-1:0]  a_r;
    logic [XLEN-1:0]  b_r;
    logic             stall_s;

    // Stall only when the last level holds a result the consumer refuses.
    always_comb begin
        stall_s = v_r[LATENCY] & ~out_ready;
    end

    // Pipeline data path: operands, tags, funct3 and product advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= {XLEN{1'b0}};
            b_r <= {XLEN{1'b0}};
            for (int i = 0; i <= LATENCY; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
                f3_r[i]  <= 3'b000;
            end
            for (int i = 1; i <= LATENCY; i++) begin
                p_r[i] <= {PW{1'b0}};
            end
        end else if (!stall_s) begin
            // Operands are only captured for real offers so idle/undriven
            // inputs never reach the product registers.
            if (in_valid) begin
                a_r      <= in_a;
                b_r      <= in_b;
                tag_r[0] <= in_tag;
                f3_r[0]  <= in_funct3;
            end
            p_r[1] <= mul_full(a_r, b_r, f3_r[0]);
            for (int i = 1; i <= LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
                f3_r[i]  <= f3_r[i-1];
            end
            for (int i = 2; i <= LATENCY; i++) begin
                p_r[i] <= p_r[i-1];
            end
        end
    end

    // Valid bits: reset and flush clear everything; flush also drops the
    // op offered in the same cycle, and beats a pending stall.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i <= LATENCY; i++) begin
                v_r[i] <= 1'b0;
            end
        end else if (!stall_s) begin
            v_r[0] <= in_valid;
            for (int i = 1; i <= LATENCY; i++) begin
                v_r[i] <= v_r[i-1];
            end
        end
    end

    // Busy whenever any level carries a live op.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            busy = busy | v_r[i];
        end
    end

    // Output port mapping from the last pipeline level.
    always_comb begin
        in_ready   = ~stall_s;
        out_valid  = v_r[LATENCY];
        out_tag    = tag_r[LATENCY];
        out_result = sel_result(p_r[LATENCY], f3_r[LATENCY]);
    end

endmodule

// File: tb/tb_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_mul_pipe
//   Directed bench for mul_pipe. Three instances (LATENCY 3, 1 and 8) see the
//   same op stream; the LATENCY=3 instance additionally gets a private
//   out_ready for the back-pressure test. Expected results are hand-computed
//   and queued per instance when an op is accepted; a negedge monitor pops
//   and compares each handshaken result, so order, loss and duplication are
//   all covered. Latency and handshake timing are checked cycle by cycle.
// ----------------------------------------------------------------------------
module tb_mul_pipe;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] res;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_funct3;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic [31:0] exp_res;

    logic        ov    [3];
    logic        irdy  [3];
    logic        ordy  [3];
    logic [31:0] ores  [3];
    logic [4:0]  otag  [3];
    logic        bsy   [3];

    int          lat   [3];
    exp_t        q     [3][$];
    exp_t        mon_e;
    logic        mon_en;

    int          n_checks;
    int          n_fail;

    mul_pipe #(.XLEN(32), .LATENCY(3), .TAG_W(5)) u_l3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(irdy[0]), .in_funct3(in_funct3),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(ores[0]),
        .out_tag(otag[0]), .busy(bsy[0])
    );

    mul_pipe #(.XLEN(32), .LATENCY(1), .TAG_W(5)) u_l1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(irdy[1]), .in_funct3(in_funct3),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_result(ores[1]),
        .out_tag(otag[1]), .busy(bsy[1])
    );

    mul_pipe #(.XLEN(32), .LATENCY(8), .TAG_W(5)) u_l8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(irdy[2]), .in_funct3(in_funct3),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_result(ores[2]),
        .out_tag(otag[2]), .busy(bsy[2])
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one op for one cycle together with its hand-computed result.
    task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        exp_res   = res;
        cyc();
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Single MUL with exact latency: out_valid only at k+LATENCY.
    task automatic test_latency();
        op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            for (int d = 0; d < 3; d++)
                check_val($sformatf("lat%0d_c%0d", lat[d], c), 64'(ov[d]), 64'(c == lat[d]));
        end
        idle(2);
    endtask

    // High-half variants plus an unsupported funct3.
    task automatic test_high();
        op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
        op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
        op(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF);
        op(3'b011, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'h0000_0001);
        op(3'b100, 32'd5,         32'd6,         5'd10, 32'h0000_0000);
        idle(10);
    endtask

    // Four back-to-back ops: four consecutive result cycles, in_ready stays 1.
    task automatic test_b2b();
        logic [2:0]  f3 [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [31:0] r  [4];
        f3 = '{3'b000, 3'b000, 3'b011, 3'b000};
        a  = '{32'd3, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF};
        b  = '{32'd4, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF};
        r  = '{32'd12, 32'd0, 32'd1, 32'd1};
        for (int c = 0; c <= 12; c++) begin
            if (c < 4) begin
                for (int d = 0; d < 3; d++)
                    check_val($sformatf("b2b_rdy%0d", lat[d]), 64'(irdy[d]), 64'd1);
                op(f3[c], a[c], b[c], 5'(c + 1), r[c]);
            end else begin
                cyc();
            end
            for (int d = 0; d < 3; d++)
                check_val($sformatf("b2b_ov%0d_c%0d", lat[d], c), 64'(ov[d]),
                          64'((c >= lat[d]) && (c <= lat[d] + 3)));
        end
        idle(2);
    endtask

    // Result collection: pop and compare every handshaken result, queue every
    // accepted op, and forget everything killed by flush or reset.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (q[d].size() == 0) begin
                        check_val($sformatf("extra%0d", lat[d]), 64'(ov[d]), 64'd0);
                    end else begin
                        mon_e = q[d].pop_front();
                        check_val($sformatf("res%0d", lat[d]), 64'(ores[d]), 64'(mon_e.res));
                        check_val($sformatf("tag%0d", lat[d]), 64'(otag[d]), 64'(mon_e.tag));
                    end
                end
                if (in_valid && irdy[d] && !flush && !reset)
                    q[d].push_back('{tag: in_tag, res: exp_res});
                if (flush || reset)
                    q[d].delete();
            end
        end
    end

    // Directed sequence.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        lat       = '{3, 1, 8};
        ordy      = '{1'b1, 1'b1, 1'b1};
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'b000;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 5'd0;
        exp_res   = 32'd0;
        idle(2);

        // Reset values
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("rst_ov%0d", lat[d]),  64'(ov[d]),   64'd0);
            check_val($sformatf("rst_res%0d", lat[d]), 64'(ores[d]), 64'd0);
            check_val($sformatf("rst_tag%0d", lat[d]), 64'(otag[d]), 64'd0);
            check_val($sformatf("rst_bsy%0d", lat[d]), 64'(bsy[d]),  64'd0);
            check_val($sformatf("rst_rdy%0d", lat[d]), 64'(irdy[d]), 64'd1);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(1);

        test_latency();
        test_high();
        test_b2b();

        // Back-pressure on the LATENCY=3 instance
        op(3'b000, 32'd2,         32'd3,         5'd9,  32'd6);
        op(3'b000, 32'd100,       32'd100,       5'd10, 32'd10000);
        op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0);
        cyc();
        ordy[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check_val("stall_ov",  64'(ov[0]),   64'd1);
            check_val("stall_res", 64'(ores[0]), 64'd6);
            check_val("stall_tag", 64'(otag[0]), 64'd9);
            check_val("stall_rdy", 64'(irdy[0]), 64'd0);
            check_val("stall_bsy", 64'(bsy[0]),  64'd1);
            cyc();
        end
        ordy[0] = 1'b1;
        idle(10);

        // Flush with two ops in flight and a third offered in the flush cycle
        op(3'b000, 32'd1, 32'd1, 5'd20, 32'd1);
        op(3'b000, 32'd2, 32'd2, 5'd21, 32'd4);
        flush = 1'b1;
        op(3'b000, 32'd3, 32'd3, 5'd22, 32'd9);
        flush = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("fl_ov%0d", lat[d]),  64'(ov[d]),  64'd0);
            check_val($sformatf("fl_bsy%0d", lat[d]), 64'(bsy[d]), 64'd0);
        end
        idle(10);
        op(3'b000, 32'd5, 32'd5, 5'd23, 32'd25);
        idle(10);

        // Reset in the cycle after an op is accepted
        op(3'b000, 32'd6, 32'd7, 5'd30, 32'd42);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("mrst_ov%0d", lat[d]),  64'(ov[d]),   64'd0);
            check_val($sformatf("mrst_res%0d", lat[d]), 64'(ores[d]), 64'd0);
            check_val($sformatf("mrst_tag%0d", lat[d]), 64'(otag[d]), 64'd0);
            check_val($sformatf("mrst_bsy%0d", lat[d]), 64'(bsy[d]),  64'd0);
        end
        idle(10);
        for (int d = 0; d < 3; d++)
            check_val($sformatf("mrst_extra%0d", lat[d]), 64'(ov[d]), 64'd0);

        test_latency();
        test_high();
        test_b2b();
        idle(10);

        for (int d = 0; d < 3; d++)
            check_val($sformatf("left%0d", lat[d]), 64'(q[d].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
